gouram_trace_drain: RTL and testbench
=====================================

# gouram_trace_drain

Consumer side of the Gouram trace port. Captures each 128-bit trace record that Gouram presents with `trace_capture_enable`, timestamps it with Gouram's `counter` value, and buffers it in a FIFO. It then serialises each buffered record into a five-beat 32-bit valid/ready stream for an off-chip link or debug DMA. It sits directly downstream of `gouram_wrapper` and decouples its one-shot capture strobe from a back-pressured sink.

## Interface
- `FIFO_DEPTH`, 8, record entries; power of two, ≥2.
- `OVF_WIDTH`, 16, width of the dropped-record counter.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `trace_data_i` in 128: trace record from Gouram `trace_data_o`.
- `trace_capture_enable_i` in 1: one-cycle strobe; the record is valid this cycle.
- `counter_i` in 32: Gouram `counter`, sampled with the strobe as the timestamp.
- `m_data_o` out 32: stream beat.
- `m_valid_o` out 1: beat valid.
- `m_last_o` out 1: final beat of a record.
- `m_ready_i` in 1: sink accepts the beat.
- `fifo_level_o` out $clog2(FIFO_DEPTH)+1: occupied entries.
- `overflow_cnt_o` out OVF_WIDTH: records dropped because the FIFO was full; saturates at all-ones.

## Operation
- **Entry format:** 160 bits, {counter_i, trace_data_i}, written on a strobe when not full.
- **Full:** `fifo_level_o == FIFO_DEPTH`, evaluated from registered state at the start of the cycle.
  - A strobe while full is dropped.
  - A dropped record increments `overflow_cnt_o`, which saturates and never wraps.
- **Serialiser:** beat index `beat` counts 0..4 over the head entry.
  - Beat 0 carries the timestamp.
  - Beats 1..4 carry data[127:96], [95:64], [63:32], [31:0].
  - `m_last_o` = (beat == 4) && `m_valid_o`.
- **Output:** `m_valid_o` = FIFO not empty.
  - `m_data_o` is muxed combinationally from the head entry's registered storage and `beat`.
- **Beat transfer:** occurs when `m_valid_o && m_ready_i`.
  - `beat` increments on each transfer.
  - On the beat-4 transfer, `beat` returns to 0 and the head entry pops.
- **Stability:** while `m_valid_o && !m_ready_i`, `m_data_o`, `m_last_o` and `beat` hold.
  - `m_valid_o` is not withdrawn until the transfer completes.
- **Simultaneous push and pop:**
  - Not full at cycle start: both happen and the level is unchanged.
  - Full at cycle start: the push is dropped (counted) even though a pop occurs.
- **Pointers:** read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The level is tracked as a separate counter.

## Timing
- **Reset (asynchronous):**
  - Pointers, level, `beat` and `overflow_cnt_o` go to 0.
  - `m_valid_o`, `m_last_o` = 0; `m_data_o` = 0 while empty.
  - FIFO storage is not reset.
- **Reset mid-frame:** a partially sent record is discarded with no further beats. The sink sees `m_valid_o` drop asynchronously.
- **Latency:** a strobe at edge N makes the record visible with `m_valid_o`=1 in the cycle after edge N.
  - No combinational path from `trace_capture_enable_i` to any output.
- **Throughput:** one beat per cycle with `m_ready_i` held high. A record drains in 5 cycles.
  - Sustained strobes faster than one per 5 cycles eventually overflow.
- **Level:** `fifo_level_o` updates on the edge of the push/pop.
- `m_ready_i` is a pure input. Asserting it while `m_valid_o`=0 has no effect.

## Test plan
- **Single record:** after reset, hold `m_ready_i`=1 and strobe data=0x0123…CDEF (128-bit), counter=0x10. Expect beats 0x00000010, 0x01234567, 0x89ABCDEF, 0x01234567, 0x89ABCDEF on consecutive cycles starting one cycle after the strobe, `m_last_o` on the 5th beat, and level back to 0.
- **Backpressure:** same record with `m_ready_i` toggled 1,0,0,1,… Every beat stays stable while stalled, there are exactly 5 transfers, and the order is unchanged.
- **Overflow:** FIFO_DEPTH=4 with `m_ready_i`=0; strobe 6 records (counter 1..6). Expect level=4 and `overflow_cnt_o`=2. After releasing ready, exactly records 1..4 emerge in order.
- **Full push+pop:** with the FIFO full, strobe in the same cycle as the beat-4 transfer. The strobed record is dropped, `overflow_cnt_o` increments by 1 and level becomes 3. A strobe one cycle later is accepted.
- **Wrap-around:** stream 3×FIFO_DEPTH records at one per 6 cycles with ready high. All emerge in order, no overflow, and the pointers have wrapped.
- **Reset mid-frame:** assert `rst_n`=0 after beat 2 of a 2-record backlog. Outputs are 0 immediately; after release the level is 0 and no stale beat appears.

Source files
------------

// File: rtl/gouram_trace_drain.sv
// Drain for the Gouram trace port: timestamps each strobed 128-bit record into a FIFO
// and replays it as a five-beat 32-bit valid/ready stream (timestamp, then data MSW first).
module gouram_trace_drain #(
    parameter int FIFO_DEPTH = 8,
    parameter int OVF_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [127:0]                  trace_data_i,
    input  logic                          trace_capture_enable_i,
    input  logic [31:0]                   counter_i,
    output logic [31:0]                   m_data_o,
    output logic                          m_valid_o,
    output logic                          m_last_o,
    input  logic                          m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [OVF_WIDTH-1:0]          overflow_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_BEAT = 3'd4;

    logic [159:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [2:0]            beat_q, beat_d;
    logic [OVF_WIDTH-1:0]  ovf_q, ovf_d;
    logic                  full, empty, push, drop, xfer, pop;
    logic [159:0]          head;

    function automatic logic [OVF_WIDTH-1:0] sat_inc(input logic [OVF_WIDTH-1:0] v);
        return (&v) ? v : v + OVF_WIDTH'(1);
    endfunction

    // Full/empty come from registered level only, so a strobe never reaches an output combinationally.
    always_comb begin
        full  = (level_q == FULL_LVL);
        empty = (level_q == '0);
        push  = trace_capture_enable_i && !full;
        drop  = trace_capture_enable_i && full;
        xfer  = !empty && m_ready_i;
        pop   = xfer && (beat_q == LAST_BEAT);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        beat_d = beat_q;
        if (xfer) begin
            beat_d = (beat_q == LAST_BEAT) ? 3'd0 : beat_q + 3'd1;
        end

        ovf_d = drop ? sat_inc(ovf_q) : ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            beat_q   <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            beat_q   <= beat_d;
            ovf_q    <= ovf_d;
        end
    end

    // Record storage carries no reset; the level counter masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {counter_i, trace_data_i};
        end
    end

    always_comb begin
        head     = mem_q[rd_ptr_q];
        m_data_o = '0;
        if (!empty) begin
            case (beat_q)
                3'd0:    m_data_o = head[159:128];
                3'd1:    m_data_o = head[127:96];
                3'd2:    m_data_o = head[95:64];
                3'd3:    m_data_o = head[63:32];
                default: m_data_o = head[31:0];
            endcase
        end
        m_valid_o = !empty;
        m_last_o  = !empty && (beat_q == LAST_BEAT);
    end

    assign fifo_level_o   = level_q;
    assign overflow_cnt_o = ovf_q;

endmodule

// File: tb/tb_gouram_trace_drain.sv
// Bench for gouram_trace_drain: a queue of expected stream words is the reference;
// each accepted record appends its five words, each modelled transfer removes one.
module tb_gouram_trace_drain;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] data = '0;
    logic         strobe = 1'b0;
    logic [31:0]  cnt = '0;
    logic         m_ready = 1'b0;
    logic [31:0]  m_data_o;
    logic         m_valid_o;
    logic         m_last_o;
    logic [2:0]   fifo_level_o;
    logic [15:0]  overflow_cnt_o;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [15:0] ovf_m = '0;

    wire [33:0] dut_out = {m_valid_o, m_last_o, m_data_o};

    gouram_trace_drain #(.FIFO_DEPTH(DEPTH), .OVF_WIDTH(16)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .trace_data_i           (data),
        .trace_capture_enable_i (strobe),
        .counter_i              (cnt),
        .m_data_o               (m_data_o),
        .m_valid_o              (m_valid_o),
        .m_last_o               (m_last_o),
        .m_ready_i              (m_ready),
        .fifo_level_o           (fifo_level_o),
        .overflow_cnt_o         (overflow_cnt_o)
    );

    always #5 clk = ~clk;

    // Records held = ceil(outstanding words / 5); a record stays until its last word is taken.
    function automatic int model_level();
        return (exp_q.size() + 4) / 5;
    endfunction

    function automatic logic [33:0] exp_out();
        if (exp_q.size() == 0) return 34'd0;
        return {1'b1, (exp_q.size() % 5) == 1, exp_q[0]};
    endfunction

    task automatic model_step();
        bit was_full;
        bit had_word;
        was_full = model_level() >= DEPTH;
        had_word = exp_q.size() != 0;
        if (had_word && m_ready) void'(exp_q.pop_front());
        if (strobe) begin
            if (!was_full) begin
                exp_q.push_back(cnt);
                exp_q.push_back(data[127:96]);
                exp_q.push_back(data[95:64]);
                exp_q.push_back(data[63:32]);
                exp_q.push_back(data[31:0]);
            end else if (ovf_m != 16'hFFFF) begin
                ovf_m = ovf_m + 16'd1;
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ovf_m = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic do_reset();
        strobe  = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (dut_out !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_out: got %h want %h", dut_out, 34'd0);
        end
        vectors++;
        if (fifo_level_o !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_level: got %0d want 0", fifo_level_o);
        end
        vectors++;
        if (overflow_cnt_o !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_ovf: got %0d want 0", overflow_cnt_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] want[5];
        want = '{32'h00000010, 32'h01234567, 32'h89ABCDEF, 32'h01234567, 32'h89ABCDEF};
        do_reset();
        m_ready = 1'b1;
        data    = 128'h0123456789ABCDEF0123456789ABCDEF;
        cnt     = 32'h10;
        strobe  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            strobe = 1'b0;
            vectors++;
            if (dut_out !== exp_out()) begin
                miscompares++;
                $display("FAIL single_model c=%0d: got %h want %h", c, dut_out, exp_out());
            end
            if (c < 5) begin
                vectors++;
                if (dut_out !== {1'b1, c == 4, want[c]}) begin
                    miscompares++;
                    $display("FAIL single_beat%0d: got %h want %h", c, dut_out, {1'b1, c == 4, want[c]});
                end
            end
        end
        vectors++;
        if (fifo_level_o !== 3'd0) begin
            miscompares++;
            $display("FAIL single_level: got %0d want 0", fifo_level_o);
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] prev_out;
        bit          prev_stall;
        int          xf;
        do_reset();
        m_ready    = 1'b1;
        data       = 128'h0123456789ABCDEF0123456789ABCDEF;
        cnt        = 32'h10;
        strobe     = 1'b1;
        prev_stall = 1'b0;
        prev_out   = '0;
        xf         = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            strobe = 1'b0;
            vectors++;
            if (dut_out !== exp_out()) begin
                miscompares++;
                $display("FAIL bp_model c=%0d: got %h want %h", c, dut_out, exp_out());
            end
            if (prev_stall) begin
                vectors++;
                if (dut_out !== prev_out) begin
                    miscompares++;
                    $display("FAIL bp_stable c=%0d: got %h want %h", c, dut_out, prev_out);
                end
            end
            m_ready    = (c % 3 == 0);
            if (m_valid_o && m_ready) xf++;
            prev_stall = m_valid_o && !m_ready;
            prev_out   = dut_out;
        end
        vectors++;
        if (xf !== 5) begin
            miscompares++;
            $display("FAIL bp_transfers: got %0d want 5", xf);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            data   = {$urandom, $urandom, $urandom, $urandom};
            cnt    = k;
            strobe = 1'b1;
            @(negedge clk);
            vectors++;
            if (dut_out !== exp_out()) begin
                miscompares++;
                $display("FAIL ovf_fill k=%0d: got %h want %h", k, dut_out, exp_out());
            end
        end
        strobe = 1'b0;
        vectors++;
        if (fifo_level_o !== 3'd4) begin
            miscompares++;
            $display("FAIL ovf_level: got %0d want 4", fifo_level_o);
        end
        vectors++;
        if (overflow_cnt_o !== 16'd2) begin
            miscompares++;
            $display("FAIL ovf_count: got %0d want 2", overflow_cnt_o);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_out !== exp_out()) begin
                miscompares++;
                $display("FAIL ovf_drain c=%0d: got %h want %h", c, dut_out, exp_out());
            end
        end
        vectors++;
        if (fifo_level_o !== 3'd0 || overflow_cnt_o !== 16'd2) begin
            miscompares++;
            $display("FAIL ovf_after: got level %0d ovf %0d want level 0 ovf 2", fifo_level_o, overflow_cnt_o);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            data   = {$urandom, $urandom, $urandom, $urandom};
            cnt    = 32'h100 + k;
            strobe = 1'b1;
            @(negedge clk);
        end
        strobe  = 1'b0;
        m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (dut_out !== exp_out()) begin
                miscompares++;
                $display("FAIL fpp_head: got %h want %h", dut_out, exp_out());
            end
        end
        data   = {$urandom, $urandom, $urandom, $urandom};
        cnt    = 32'hAA;
        strobe = 1'b1;
        @(negedge clk);
        vectors++;
        if (fifo_level_o !== 3'd3 || overflow_cnt_o !== 16'd1) begin
            miscompares++;
            $display("FAIL fpp_drop: got level %0d ovf %0d want level 3 ovf 1", fifo_level_o, overflow_cnt_o);
        end
        data    = {$urandom, $urandom, $urandom, $urandom};
        cnt     = 32'hBB;
        m_ready = 1'b0;
        @(negedge clk);
        strobe = 1'b0;
        vectors++;
        if (fifo_level_o !== 3'd4 || overflow_cnt_o !== 16'd1) begin
            miscompares++;
            $display("FAIL fpp_accept: got level %0d ovf %0d want level 4 ovf 1", fifo_level_o, overflow_cnt_o);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_out !== exp_out()) begin
                miscompares++;
                $display("FAIL fpp_drain c=%0d: got %h want %h", c, dut_out, exp_out());
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        m_ready = 1'b1;
        for (int r = 0; r < 3 * DEPTH + 1; r++) begin
            for (int c = 0; c < 6; c++) begin
                strobe = (c == 0) && (r < 3 * DEPTH);
                data   = {$urandom, $urandom, $urandom, $urandom};
                cnt    = $urandom;
                @(negedge clk);
                strobe = 1'b0;
                vectors++;
                if (dut_out !== exp_out() || fifo_level_o !== 3'(model_level())) begin
                    miscompares++;
                    $display("FAIL wrap r=%0d c=%0d: got %h/%0d want %h/%0d", r, c, dut_out,
                             fifo_level_o, exp_out(), model_level());
                end
            end
        end
        vectors++;
        if (overflow_cnt_o !== 16'd0) begin
            miscompares++;
            $display("FAIL wrap_ovf: got %0d want 0", overflow_cnt_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            strobe  = ($urandom_range(0, 2) == 0);
            m_ready = ($urandom_range(0, 1) == 1);
            data    = {$urandom, $urandom, $urandom, $urandom};
            cnt     = $urandom;
            @(negedge clk);
            vectors++;
            if (dut_out !== exp_out() || fifo_level_o !== 3'(model_level()) || overflow_cnt_o !== ovf_m) begin
                miscompares++;
                $display("FAIL random c=%0d: got %h/%0d/%0d want %h/%0d/%0d", c, dut_out, fifo_level_o,
                         overflow_cnt_o, exp_out(), model_level(), ovf_m);
            end
        end
        strobe = 1'b0;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            data   = {$urandom, $urandom, $urandom, $urandom};
            cnt    = 32'h200 + k;
            strobe = 1'b1;
            @(negedge clk);
        end
        strobe  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dut_out !== 34'd0 || fifo_level_o !== 3'd0) begin
            miscompares++;
            $display("FAIL midreset_async: got %h/%0d want 0/0", dut_out, fifo_level_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_out !== 34'd0 || fifo_level_o !== 3'd0 || dut_out !== exp_out()) begin
                miscompares++;
                $display("FAIL midreset_after c=%0d: got %h/%0d want 0/0", c, dut_out, fifo_level_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pushpop();
        test_wrap();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
